// File: rtl/roe_seq_pkg.sv
// Shared types and default widths for the program-counter sequencer.
package roe_seq_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_CNT_W  = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/seq_perf_counters.sv
// Saturating retired-instruction and busy-cycle counters for pc_sequencer.
// Only compiled when ROE_SEQ_PERF_CNT_EN is defined; otherwise the
// sequencer ties its counter ports to zero and this module does not exist.
`ifdef ROE_SEQ_PERF_CNT_EN
module seq_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             busy,
  input  logic             retire,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count
);

  // Count retirements and busy cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      instr_count <= '0;
      cycle_count <= '0;
    end else begin
      if (retire && (instr_count != '1)) instr_count <= instr_count + 1'b1;
      if (busy && (cycle_count != '1))   cycle_count <= cycle_count + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/pc_sequencer.sv
// Fetch/execute control FSM that steers an external program counter.
// Optional performance counters are enabled by defining ROE_SEQ_PERF_CNT_EN.
module pc_sequencer
  import roe_seq_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] END_ADDR = {ADDR_W{1'b1}},
  parameter int                CNT_W    = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              pc_reset,
  output logic              pc_halt,
  output logic              pc_bnz,
  output logic [ADDR_W-1:0] pc_jump_here,
  output logic              imem_req,
  input  logic              imem_ack,
  output logic              instr_valid,
  input  logic              exec_done,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              halt_req,
  output logic [CNT_W-1:0]  instr_count,
  output logic [CNT_W-1:0]  cycle_count
);

  seq_state_t state, next_state;
  logic       restart_q;
  logic       restart;
  logic       retire;

  // A start seen in S_HALT passes through one S_IDLE cycle (PC reset) and
  // then fetches without needing start to be held.
  assign restart = (state == S_HALT) && start;

  // State register and restart marker.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      restart_q <= 1'b0;
    end else begin
      state     <= next_state;
      restart_q <= restart;
    end
  end

  // Next-state and PC-control decode from current state and inputs.
  // NOTE: every output gets a default first so no path leaves a latch.
  always_comb begin
    next_state   = state;
    pc_reset     = 1'b0;
    pc_halt      = 1'b0;
    pc_bnz       = 1'b0;
    pc_jump_here = '0;
    imem_req     = 1'b0;
    instr_valid  = 1'b0;
    done         = 1'b0;
    retire       = 1'b0;
    case (state)
      S_IDLE: begin
        pc_reset = 1'b1;
        if (start || restart_q) next_state = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        pc_halt  = 1'b1;
        if (imem_ack) begin
          instr_valid = 1'b1;
          next_state  = S_EXEC;
        end
      end
      S_EXEC: begin
        pc_halt = 1'b1;
        if (exec_done) begin
          retire = 1'b1;
          if (halt_req) begin
            next_state = S_HALT;
          end else if (br_taken) begin
            pc_halt      = 1'b0;
            pc_bnz       = 1'b1;
            pc_jump_here = br_target;
            next_state   = S_FETCH;
          end else if (pc_addr == END_ADDR) begin
            // Last address retired: freeze rather than wrap to zero.
            next_state = S_HALT;
          end else begin
            pc_halt    = 1'b0;
            next_state = S_FETCH;
          end
        end
      end
      S_HALT: begin
        done    = 1'b1;
        pc_halt = 1'b1;
        if (start) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

`ifdef ROE_SEQ_PERF_CNT_EN
  seq_perf_counters #(.CNT_W(CNT_W)) u_perf (
    .clk         (clk),
    .reset       (reset),
    .clear       (restart),
    .busy        ((state == S_FETCH) || (state == S_EXEC)),
    .retire      (retire),
    .instr_count (instr_count),
    .cycle_count (cycle_count)
  );
`else
  assign instr_count = '0;
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: an external PC model follows the
// sequencer's controls, the stimulus pushes each expected fetch address,
// and a monitor pops and compares on every instr_valid pulse.
module tb_pc_sequencer;

  localparam int          ADDR_W = 16;
  localparam int          CNT_W  = 32;
  localparam logic [15:0] END_A  = 16'h0007;
`ifdef ROE_SEQ_PERF_CNT_EN
  localparam logic [31:0] EXP_INSTR = 32'd5;
  localparam logic [31:0] EXP_CYC   = 32'd12;
`else
  localparam logic [31:0] EXP_INSTR = 32'd0;
  localparam logic [31:0] EXP_CYC   = 32'd0;
`endif

  logic              clk = 1'b0;
  logic              reset, start, done;
  logic [ADDR_W-1:0] pc_addr = '0;
  logic              pc_reset, pc_halt, pc_bnz;
  logic [ADDR_W-1:0] pc_jump_here;
  logic              imem_req, imem_ack, instr_valid;
  logic              exec_done, br_taken, halt_req;
  logic [ADDR_W-1:0] br_target;
  logic [CNT_W-1:0]  instr_count, cycle_count;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];

  pc_sequencer #(.ADDR_W(ADDR_W), .END_ADDR(END_A), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .done         (done),
    .pc_addr      (pc_addr),
    .pc_reset     (pc_reset),
    .pc_halt      (pc_halt),
    .pc_bnz       (pc_bnz),
    .pc_jump_here (pc_jump_here),
    .imem_req     (imem_req),
    .imem_ack     (imem_ack),
    .instr_valid  (instr_valid),
    .exec_done    (exec_done),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .halt_req     (halt_req),
    .instr_count  (instr_count),
    .cycle_count  (cycle_count)
  );

  always #5 clk = ~clk;

  // External program counter driven by the sequencer's controls.
  always @(posedge clk) begin
    if (pc_reset)      pc_addr <= '0;
    else if (!pc_halt) pc_addr <= pc_bnz ? pc_jump_here : pc_addr + 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: each instr_valid pulse must match the next expected fetch address.
  always @(negedge clk) begin
    if (reset === 1'b0 && instr_valid === 1'b1) begin
      if (exp_q.size() == 0) check("extra_instr_valid", 32'd1, 32'd0);
      else check("fetch_addr", {16'd0, pc_addr}, {16'd0, exp_q.pop_front()});
    end
  end

  task automatic clear_inputs();
    start = 1'b0; imem_ack = 1'b0; exec_done = 1'b0;
    br_taken = 1'b0; halt_req = 1'b0; br_target = '0;
  endtask

  // One instruction starting in S_FETCH; returns #1 after the retire edge.
  // Wait cycles drive ignored inputs high to show they have no effect.
  task automatic do_instr(input logic [15:0] addr, input int aw, input int ew,
                          input logic br, input logic [15:0] tgt, input logic hlt,
                          input logic e_bnz, input logic e_halt, input logic [15:0] e_jump);
    exp_q.push_back(addr);
    for (int i = 0; i < aw; i++) begin
      clear_inputs();
      start = 1'b1; exec_done = 1'b1; br_taken = 1'b1; halt_req = 1'b1; br_target = 16'h00AA;
      @(negedge clk);
      check("fetch_wait_halt", {31'd0, pc_halt}, 32'd1);
      check("fetch_wait_bnz", {31'd0, pc_bnz}, 32'd0);
      check("fetch_wait_req", {31'd0, imem_req}, 32'd1);
      check("fetch_wait_pc", {16'd0, pc_addr}, {16'd0, addr});
      @(posedge clk); #1;
    end
    clear_inputs();
    imem_ack = 1'b1;
    @(negedge clk);
    check("fetch_req", {31'd0, imem_req}, 32'd1);
    check("fetch_pc_reset", {31'd0, pc_reset}, 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < ew; i++) begin
      clear_inputs();
      imem_ack = 1'b1; start = 1'b1;
      @(negedge clk);
      check("exec_wait_halt", {31'd0, pc_halt}, 32'd1);
      check("exec_wait_req", {31'd0, imem_req}, 32'd0);
      check("exec_wait_pc", {16'd0, pc_addr}, {16'd0, addr});
      @(posedge clk); #1;
    end
    clear_inputs();
    exec_done = 1'b1; br_taken = br; br_target = tgt; halt_req = hlt;
    @(negedge clk);
    check("retire_bnz", {31'd0, pc_bnz}, {31'd0, e_bnz});
    check("retire_halt", {31'd0, pc_halt}, {31'd0, e_halt});
    check("retire_jump", {16'd0, pc_jump_here}, {16'd0, e_jump});
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic idle_state_checks(input string tag);
    check({tag, "_pc_reset"}, {31'd0, pc_reset}, 32'd1);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    check({tag, "_ivalid"}, {31'd0, instr_valid}, 32'd0);
    check({tag, "_halt"}, {31'd0, pc_halt}, 32'd0);
    check({tag, "_bnz"}, {31'd0, pc_bnz}, 32'd0);
    check({tag, "_jump"}, {16'd0, pc_jump_here}, 32'd0);
  endtask

  task automatic halted_checks(input logic [15:0] pc);
    @(negedge clk);
    check("halt_done", {31'd0, done}, 32'd1);
    check("halt_freeze", {31'd0, pc_halt}, 32'd1);
    check("halt_pc", {16'd0, pc_addr}, {16'd0, pc});
    @(posedge clk); #1;
    @(negedge clk);
    check("halt_pc_hold", {16'd0, pc_addr}, {16'd0, pc});
    @(posedge clk); #1;
  endtask

  // Restart from S_HALT: one start pulse, one S_IDLE cycle, then fetch.
  task automatic restart_from_halt();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    idle_state_checks("restart_idle");
    check("restart_instr_cnt", instr_count, 32'd0);
    check("restart_cycle_cnt", cycle_count, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    idle_state_checks("reset");
    check("reset_instr_cnt", instr_count, 32'd0);
    check("reset_cycle_cnt", cycle_count, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b1;
    @(negedge clk);
    idle_state_checks("start_idle");
    @(posedge clk); #1;
    start = 1'b0;

    // Straight-line, single-cycle ack/done.
    do_instr(16'h0000, 0, 0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    do_instr(16'h0001, 0, 0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    do_instr(16'h0002, 0, 0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    // Slow memory and slow execute.
    do_instr(16'h0003, 4, 3, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    do_instr(16'h0004, 0, 0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    // Taken branch at pc 5.
    do_instr(16'h0005, 0, 0, 1'b1, 16'h0040, 1'b0, 1'b1, 1'b0, 16'h0040);
    do_instr(16'h0040, 0, 0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    // Halt together with a taken branch: halt wins, no jump.
    do_instr(16'h0041, 0, 0, 1'b1, 16'h0010, 1'b1, 1'b0, 1'b1, 16'h0000);
    halted_checks(16'h0041);

    // Restart and run straight-line up to the end address.
    restart_from_halt();
    for (int a = 0; a < 7; a++)
      do_instr(16'(a), 0, 0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    do_instr(16'h0007, 0, 0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000);
    halted_checks(16'h0007);

    // Five instructions in twelve busy cycles, then reset mid-execute.
    restart_from_halt();
    do_instr(16'h0000, 0, 0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    do_instr(16'h0001, 0, 0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    do_instr(16'h0002, 1, 0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    do_instr(16'h0003, 0, 1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    do_instr(16'h0004, 0, 0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    exp_q.push_back(16'h0005);
    imem_ack = 1'b1;
    @(negedge clk);
    check("pre_reset_instr_cnt", instr_count, EXP_INSTR);
    check("pre_reset_cycle_cnt", cycle_count, EXP_CYC);
    @(posedge clk); #1;
    clear_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    idle_state_checks("mid_exec_reset");
    check("mid_exec_reset_instr_cnt", instr_count, 32'd0);
    check("mid_exec_reset_cycle_cnt", cycle_count, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    idle_state_checks("post_reset_idle");
    check("post_reset_pc", {16'd0, pc_addr}, 32'd0);
    @(posedge clk); #1;

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
